// File: rtl/prefix_decode_unit_if.sv
// Handshake bundle between fetch, the index-operand memory and decode.
// The slave modport is the prefix decode unit's view; master is its environment.
interface prefix_decode_unit_if #(
   parameter int WORD_W = 15,
   parameter int PC_W   = 12,
   parameter int ADDR_W = 12
);
   logic              in_valid;
   logic              in_ready;
   logic [WORD_W-1:0] in_instr;
   logic [PC_W-1:0]   in_pc;

   logic              idx_req;
   logic [ADDR_W-1:0] idx_addr;
   logic              idx_valid;
   logic [WORD_W-1:0] idx_data;

   logic              out_valid;
   logic              out_ready;
   logic [WORD_W-1:0] out_instr;
   logic              out_ext;
   logic              out_indexed;
   logic [PC_W-1:0]   out_pc;
   logic [PC_W-1:0]   out_restart_pc;

   logic              int_ok;
   logic              chain_err;

   modport slave (
      input  in_valid, in_instr, in_pc, idx_valid, idx_data, out_ready,
      output in_ready, idx_req, idx_addr, out_valid, out_instr, out_ext,
             out_indexed, out_pc, out_restart_pc, int_ok, chain_err
   );

   modport master (
      output in_valid, in_instr, in_pc, idx_valid, idx_data, out_ready,
      input  in_ready, idx_req, idx_addr, out_valid, out_instr, out_ext,
             out_indexed, out_pc, out_restart_pc, int_ok, chain_err
   );
endinterface

// File: rtl/prefix_decode_unit.sv
// Absorbs EXTEND/INDEX prefix words and hands decode one resolved word per handshake.
//
// state       | meaning
// S_NORM      | no prefix pending
// S_EXT       | EXTEND seen, next word is an extracode
// S_IDX_FETCH | idx_req held high until idx_valid
// S_IDX_HOLD  | index value held, waiting for the next word
module prefix_decode_unit #(
    parameter int                WORD_W      = 15,
    parameter int                PC_W        = 12,
    parameter int                ADDR_W      = 12,
    parameter logic [WORD_W-1:0] EXTEND_WORD = WORD_W'(6),
    parameter int                MAX_CHAIN   = 4
) (
    input  logic                 clock,
    input  logic                 rst,
    input  logic                 flush,
    prefix_decode_unit_if.slave  bus
);
    localparam logic [1:0] S_NORM      = 2'd0;
    localparam logic [1:0] S_EXT       = 2'd1;
    localparam logic [1:0] S_IDX_FETCH = 2'd2;
    localparam logic [1:0] S_IDX_HOLD  = 2'd3;
    localparam int         CNT_W       = $clog2(MAX_CHAIN + 1);

    logic [1:0]        state;
    logic              ext_q;
    logic [WORD_W-1:0] idx_q;
    logic [CNT_W-1:0]  chain_cnt;
    logic [PC_W-1:0]   restart_pc_q;
    logic              idx_req_q;
    logic [ADDR_W-1:0] idx_addr_q;
    logic              chain_err_q;

    logic              out_valid_q;
    logic [WORD_W-1:0] out_instr_q;
    logic              out_ext_q;
    logic              out_indexed_q;
    logic [PC_W-1:0]   out_pc_q;
    logic [PC_W-1:0]   out_restart_pc_q;

    logic              in_ready_int;
    logic              accept;
    logic [WORD_W-1:0] eff;
    logic [2:0]        eff_op;
    logic [1:0]        eff_mode;
    logic              is_ext;
    logic              is_idx_ext;
    logic              is_idx_norm;
    logic              is_prefix;
    logic              chain_full;

    assign in_ready_int = (!out_valid_q || bus.out_ready) && (state != S_IDX_FETCH);
    assign accept       = bus.in_valid && in_ready_int;

    // idx_q is cleared whenever the unit leaves S_IDX_HOLD, so the add is a no-op otherwise
    assign eff      = bus.in_instr + idx_q;
    assign eff_op   = eff[WORD_W-1 -: 3];
    assign eff_mode = eff[WORD_W-4 -: 2];

    assign is_ext      = (eff == EXTEND_WORD) && !ext_q;
    assign is_idx_ext  = ext_q && (eff_op == 3'd5);
    assign is_idx_norm = !ext_q && (eff_op == 3'd5) && (eff_mode == 2'd0);
    assign is_prefix   = is_ext || is_idx_ext || is_idx_norm;
    assign chain_full  = (chain_cnt == CNT_W'(MAX_CHAIN));

    always_ff @(posedge clock) begin
        if (rst || flush) begin
            state            <= S_NORM;
            ext_q            <= 1'b0;
            idx_q            <= '0;
            chain_cnt        <= '0;
            restart_pc_q     <= '0;
            idx_req_q        <= 1'b0;
            idx_addr_q       <= '0;
            chain_err_q      <= 1'b0;
            out_valid_q      <= 1'b0;
            out_instr_q      <= '0;
            out_ext_q        <= 1'b0;
            out_indexed_q    <= 1'b0;
            out_pc_q         <= '0;
            out_restart_pc_q <= '0;
        end else begin
            chain_err_q <= 1'b0;
            if (out_valid_q && bus.out_ready) begin
                out_valid_q <= 1'b0;
            end

            if (state == S_IDX_FETCH) begin
                if (bus.idx_valid) begin
                    idx_q     <= bus.idx_data;
                    idx_req_q <= 1'b0;
                    state     <= S_IDX_HOLD;
                end
            end else if (accept) begin
                if (is_prefix) begin
                    idx_q <= '0;
                    if (chain_full) begin
                        // overflowing prefix is dropped and the chain abandoned
                        chain_err_q <= 1'b1;
                        ext_q       <= 1'b0;
                        chain_cnt   <= '0;
                        state       <= S_NORM;
                    end else begin
                        chain_cnt <= chain_cnt + CNT_W'(1);
                        if (chain_cnt == '0) begin
                            restart_pc_q <= bus.in_pc;
                        end
                        if (is_ext) begin
                            ext_q <= 1'b1;
                            state <= S_EXT;
                        end else begin
                            idx_req_q  <= 1'b1;
                            idx_addr_q <= is_idx_ext ? eff[ADDR_W-1:0] : ADDR_W'(eff[9:0]);
                            state      <= S_IDX_FETCH;
                        end
                    end
                end else begin
                    out_valid_q      <= 1'b1;
                    out_instr_q      <= eff;
                    out_ext_q        <= ext_q;
                    out_indexed_q    <= (state == S_IDX_HOLD);
                    out_pc_q         <= bus.in_pc;
                    out_restart_pc_q <= (chain_cnt != '0) ? restart_pc_q : bus.in_pc;
                    ext_q            <= 1'b0;
                    idx_q            <= '0;
                    chain_cnt        <= '0;
                    state            <= S_NORM;
                end
            end
        end
    end

    assign bus.in_ready       = in_ready_int;
    assign bus.idx_req        = idx_req_q;
    assign bus.idx_addr       = idx_addr_q;
    assign bus.out_valid      = out_valid_q;
    assign bus.out_instr      = out_instr_q;
    assign bus.out_ext        = out_ext_q;
    assign bus.out_indexed    = out_indexed_q;
    assign bus.out_pc         = out_pc_q;
    assign bus.out_restart_pc = out_restart_pc_q;
    assign bus.int_ok         = (state == S_NORM) && !ext_q;
    assign bus.chain_err      = chain_err_q;
endmodule

// File: doc/prefix_decode_unit.md
Name: prefix_decode_unit

Overview:
- Front-end stage between fetch and `decode`. It absorbs EXTEND and INDEX prefix words and delivers one fully resolved instruction per handshake.
- Each output word carries an extended flag and has the index value already added.
- Generalises the single-cycle extend/index flops: variable-latency index-operand fetch, valid/ready backpressure, chained prefixes, an interrupt-safe boundary and a restart PC.

Parameters:
- WORD_W, 15, instruction/data word width.
- PC_W, 12, program counter width.
- ADDR_W, 12, index operand address width.
- EXTEND_WORD, 'o00006, encoding of EXTEND.
- MAX_CHAIN, 4, maximum consecutive prefix words before an error.

Ports:
- clock  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  pipeline flush; discards all prefix state and the output buffer.
- in_valid  in  1  fetch word valid.
- in_ready  out  1  unit accepts word.
- in_instr  in  WORD_W  fetched word.
- in_pc  in  PC_W  address of the fetched word.
- idx_req  out  1  index operand read request.
- idx_addr  out  ADDR_W  index operand address.
- idx_valid  in  1  index operand returned.
- idx_data  in  WORD_W  index operand.
- out_valid  out  1  resolved instruction valid.
- out_ready  in  1  decode accepts.
- out_instr  out  WORD_W  resolved (indexed) word.
- out_ext  out  1  word is an extracode.
- out_indexed  out  1  index value was applied.
- out_pc  out  PC_W  PC of the resolved word.
- out_restart_pc  out  PC_W  PC of the first prefix in the chain, else out_pc.
- int_ok  out  1  interrupt-safe boundary.
- chain_err  out  1  one-cycle pulse on a prefix chain overflow.

Behaviour:
- Reset/flush: state=S_NORM; ext_q=0; idx_q=0; chain count=0; out_valid=0; idx_req=0; chain_err=0; int_ok=1. Reset has priority over flush; flush has priority over every other event.
- FSM states:
  - S_NORM: no prefix pending.
  - S_EXT: EXTEND seen.
  - S_IDX_FETCH: idx_req held high until idx_valid.
  - S_IDX_HOLD: index value held, waiting for the next word.
- in_ready = (!out_valid | out_ready) & state != S_IDX_FETCH.
- Effective word eff = in_instr + idx_q, computed modulo 2^WORD_W; idx_q is 0 unless holding.
- Prefix classification uses eff, so an indexed INDEX uses its modified address.
- On accept in S_NORM, S_EXT or S_IDX_HOLD:
  - EXTEND: eff==EXTEND_WORD and ext_q==0.
    - Set ext_q=1 and go to S_EXT. No output.
    - When ext_q==1, 'o00006 is an ordinary extracode word and is emitted.
  - Non-extended INDEX: eff[14:12]==5 and eff[11:10]==0.
    - idx_addr = zero-extended eff[9:0]; ext_q cleared; go to S_IDX_FETCH.
  - Extended INDEX: ext_q==1 and eff[14:12]==5.
    - idx_addr = eff[11:0]; ext_q stays 1, so the following word is extended; go to S_IDX_FETCH.
  - Any other word: load the output register with out_instr=eff, out_ext=ext_q, out_indexed=(state==S_IDX_HOLD), out_pc=in_pc.
    - Clear ext_q, idx_q and chain count; go to S_NORM.
- Prefix chain bookkeeping:
  - The first prefix of a chain captures in_pc as the restart PC.
  - Each prefix increments the chain count.
  - A prefix arriving with count==MAX_CHAIN pulses chain_err, is dropped, and returns the unit to reset state.
- S_IDX_FETCH:
  - On idx_valid, idx_q=idx_data and go to S_IDX_HOLD; idx_req drops the same edge.
  - Memory never responds after idx_req falls, so an abort through flush needs no drain.
- Latency: a non-prefix word accepted at edge N has out_valid high after edge N. Each prefix word adds its own accept cycle; INDEX adds the idx round trip.
- Output register:
  - Holds its contents while out_valid & !out_ready.
  - Simultaneous drain and refill in one cycle is allowed, giving full throughput.
- int_ok = (state==S_NORM) & !ext_q.

Test Plan:
- Reset, then words 'o30100 (pc 'o4000) and 'o60101 back-to-back, out_ready=1 -> out_instr 'o30100 then 'o60101 on consecutive cycles, out_ext=0, int_ok stays 1.
- 'o00006 at pc 'o4000 then 'o70100 at 'o4001 -> single output 'o70100, out_ext=1, out_pc='o4001, out_restart_pc='o4000; int_ok=0 between the two words.
- 'o50200 then idx_valid 3 cycles after idx_req with idx_data='o00002, then 'o30100 -> idx_addr='o0200, output 'o30102 with out_indexed=1; EXTEND,'o50200,data 'o00001,'o70100 -> output 'o70101 with out_ext=1.
- Index wrap: idx_data='o77777, next word 'o00001 -> out_instr='o00000. Nested INDEX: 'o50200, data 'o00001, then 'o50200 -> second idx_addr='o0201.
- flush asserted while in S_IDX_FETCH -> idx_req=0 next cycle, int_ok=1. Next word 'o30100 emitted unmodified with out_ext=0.
- out_ready held 0 with a loaded output -> in_ready=0 and outputs stable for 5 cycles. MAX_CHAIN+1 consecutive INDEX words -> exactly one chain_err pulse, then reset state.
